// File: rtl/fpga_usb_wb_bridge.sv
// FX2 slave-FIFO to Wishbone bridge: each OUT command frame runs one Wishbone
// single transfer on an internal register file and returns a response on EP6.
module fpga_usb_wb_bridge #(
  parameter int LOGMAXPKG = 9,
  parameter int REG_WORDS = 16
) (
  input  logic                 USB_IFCLK,
  input  logic                 RST_N,
  input  logic                 USB_FLAGA,
  input  logic                 USB_FLAGB,
  input  logic                 USB_FLAGC,
  input  logic                 USB_FLAGD,
  inout  wire  [15:0]          USB_DATA,
  output logic [1:0]           USB_ADDR,
  output logic                 USB_SLRD,
  output logic                 USB_SLWR,
  output logic                 USB_SLOE,
  output logic                 USB_PKEND,
  output logic [3:0]           LED,
  output logic [LOGMAXPKG-1:0] COUNTER,
  output logic                 WB_RST,
  output logic                 WB_STB,
  output logic                 WB_WE,
  output logic                 WB_CYC,
  output logic [3:0]           WB_SEL,
  output logic [31:0]          WB_ADDR,
  output logic [31:0]          WB_DATA_I,
  output logic [31:0]          WB_DATA_O,
  output logic                 WB_STALL,
  output logic                 WB_ACK
);

  // REG_WORDS is expected to be a power of two; the word index comes straight
  // from the byte address above the two byte-lane bits.
  localparam int IDX_W = $clog2(REG_WORDS);
  localparam logic [LOGMAXPKG-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WB, S_TURN, S_WR, S_PKEND} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [LOGMAXPKG-1:0] word_cnt;
  logic                 hdr_we;
  logic [3:0]           hdr_sel;
  logic [7:0]           hdr_tag;
  logic [31:0]          frm_addr;
  logic [31:0]          frm_data;
  logic [31:0]          rsp_data;
  logic [1:0]           rsp_idx;
  logic [15:0]          rsp_word;
  logic                 stb_q;
  logic                 data_oe;
  logic                 rd_fire;
  logic                 wr_fire;
  logic                 frame_last;
  logic                 rsp_last;
  logic [31:0]          regs [REG_WORDS];
  logic                 ack_q;
  logic [31:0]          dat_i_q;
  logic [IDX_W-1:0]     wb_idx;
  logic                 wb_hit;
  logic                 unused_flags;

  assign unused_flags = USB_FLAGB ^ USB_FLAGC;

  // Strobes are qualified by RST_N so a reset cycle can never pop or push a word.
  assign rd_fire    = (state == S_RD) && USB_FLAGA && RST_N;
  assign wr_fire    = (state == S_WR) && USB_FLAGD && RST_N;
  assign frame_last = hdr_we ? (word_cnt == LOGMAXPKG'(4)) : (word_cnt == LOGMAXPKG'(2));
  assign rsp_last   = hdr_we ? (rsp_idx == 2'd0) : (rsp_idx == 2'd2);

  always_comb begin
    rsp_word = rsp_data[15:0];
    case (rsp_idx)
      2'd0:    rsp_word = {8'hA5, hdr_tag};
      2'd1:    rsp_word = rsp_data[31:16];
      default: rsp_word = rsp_data[15:0];
    endcase
  end

  assign USB_DATA = data_oe ? rsp_word : 16'hzzzz;
  assign COUNTER  = word_cnt;

  always_ff @(posedge USB_IFCLK) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    USB_ADDR  = 2'b00;
    USB_SLRD  = 1'b1;
    USB_SLWR  = 1'b1;
    USB_SLOE  = 1'b1;
    USB_PKEND = 1'b1;
    data_oe   = 1'b0;
    case (state)
      S_IDLE: begin
        if (USB_FLAGA) state_nxt = S_RD;
      end
      S_RD: begin
        USB_SLOE = 1'b0;
        USB_SLRD = ~rd_fire;
        if (rd_fire && frame_last) state_nxt = S_WB;
      end
      S_WB: begin
        if (WB_ACK) state_nxt = S_TURN;
      end
      S_TURN: begin
        USB_ADDR  = 2'b10;
        state_nxt = S_WR;
      end
      S_WR: begin
        USB_ADDR = 2'b10;
        data_oe  = RST_N;
        USB_SLWR = ~wr_fire;
        if (wr_fire && rsp_last) state_nxt = S_PKEND;
      end
      S_PKEND: begin
        USB_ADDR  = 2'b10;
        USB_PKEND = ~RST_N;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame capture, Wishbone strobe and response sequencing.
  always_ff @(posedge USB_IFCLK) begin
    if (!RST_N) begin
      word_cnt <= '0;
      hdr_we   <= 1'b0;
      hdr_sel  <= 4'h0;
      hdr_tag  <= 8'h00;
      frm_addr <= 32'h0;
      frm_data <= 32'h0;
      rsp_data <= 32'h0;
      rsp_idx  <= 2'd0;
      stb_q    <= 1'b0;
    end else begin
      if (state == S_IDLE) word_cnt <= '0;
      if (rd_fire) begin
        word_cnt <= (word_cnt != CNT_MAX) ? word_cnt + LOGMAXPKG'(1) : word_cnt;
        if (word_cnt == LOGMAXPKG'(0)) begin
          hdr_we  <= USB_DATA[15];
          hdr_sel <= USB_DATA[11:8];
          hdr_tag <= USB_DATA[7:0];
        end
        if (word_cnt == LOGMAXPKG'(1)) frm_addr[31:16] <= USB_DATA;
        if (word_cnt == LOGMAXPKG'(2)) frm_addr[15:0]  <= USB_DATA;
        if (word_cnt == LOGMAXPKG'(3)) frm_data[31:16] <= USB_DATA;
        if (word_cnt == LOGMAXPKG'(4)) frm_data[15:0]  <= USB_DATA;
      end
      if (state == S_RD && state_nxt == S_WB) stb_q <= 1'b1;
      else if (stb_q && !WB_STALL)            stb_q <= 1'b0;
      if (state == S_WB && WB_ACK) rsp_data <= WB_DATA_I;
      if (state == S_TURN)         rsp_idx  <= 2'd0;
      else if (wr_fire)            rsp_idx  <= rsp_idx + 2'd1;
    end
  end

  assign WB_CYC    = (state == S_WB);
  assign WB_STB    = stb_q && WB_CYC;
  assign WB_WE     = WB_CYC && hdr_we;
  assign WB_SEL    = WB_CYC ? hdr_sel : 4'h0;
  assign WB_ADDR   = WB_CYC ? frm_addr : 32'h0;
  assign WB_DATA_O = WB_WE ? frm_data : 32'h0;
  assign WB_STALL  = 1'b0;
  assign WB_ACK    = ack_q;
  assign WB_DATA_I = dat_i_q;

  always_ff @(posedge USB_IFCLK) begin
    WB_RST <= ~RST_N;
  end

  // Internal slave: out-of-range addresses still ack, read as zero, drop writes.
  assign wb_idx = WB_ADDR[IDX_W+1:2];
  assign wb_hit = (WB_ADDR[31:IDX_W+2] == '0);

  always_ff @(posedge USB_IFCLK) begin
    if (!RST_N) begin
      for (int i = 0; i < REG_WORDS; i++) regs[i] <= 32'h0;
      ack_q   <= 1'b0;
      dat_i_q <= 32'h0;
    end else begin
      ack_q   <= WB_STB && WB_CYC;
      dat_i_q <= 32'h0;
      if (WB_STB && WB_CYC) begin
        if (!WB_WE) begin
          dat_i_q <= wb_hit ? regs[wb_idx] : 32'h0;
        end else if (wb_hit) begin
          for (int b = 0; b < 4; b++)
            if (WB_SEL[b]) regs[wb_idx][8*b +: 8] <= WB_DATA_O[8*b +: 8];
        end
      end
    end
  end

  assign LED = regs[0][3:0];

endmodule

// File: tb/tb_fpga_usb_wb_bridge.sv
// Directed bench for fpga_usb_wb_bridge: models the FX2 FIFOs around the DUT
// and checks frames, responses, Wishbone activity and flow control.
module tb_fpga_usb_wb_bridge;

  localparam int LOGMAXPKG = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 flaga_en;
  logic                 flagd_en;
  logic                 usb_flaga;
  logic                 usb_flagd;
  wire  [15:0]          usb_data;
  logic [1:0]           usb_addr;
  logic                 usb_slrd, usb_slwr, usb_sloe, usb_pkend;
  logic [3:0]           led;
  logic [LOGMAXPKG-1:0] counter;
  logic                 wb_rst, wb_stb, wb_we, wb_cyc, wb_stall, wb_ack;
  logic [3:0]           wb_sel;
  logic [31:0]          wb_addr, wb_data_i, wb_data_o;

  logic [15:0] out_mem [64];
  logic [5:0]  out_rd = 6'd0;
  logic [5:0]  out_wr = 6'd0;
  logic        rd_pend = 1'b0;
  logic [15:0] in_mem [64];
  int          in_cnt = 0;
  int          pk_cnt = 0;
  int          viol = 0;
  int          ncyc = 0;
  int          stb_at = 0;
  int          ack_lat = 0;
  logic        txn_we = 1'b0;
  logic [3:0]  txn_sel = 4'h0;
  logic [31:0] txn_addr = 32'h0, txn_dout = 32'h0, txn_din = 32'h0;
  logic [LOGMAXPKG-1:0] txn_counter = '0;
  int          checks = 0;
  int          failures = 0;
  int          in0 = 0;
  int          pk0 = 0;

  // The FX2 drives the bus whenever SLOE is low; the OUT FIFO flag reflects data present.
  assign usb_flaga = flaga_en && (out_rd != out_wr);
  assign usb_flagd = flagd_en;
  assign usb_data  = (usb_sloe == 1'b0) ? out_mem[out_rd] : 16'hzzzz;

  fpga_usb_wb_bridge #(.LOGMAXPKG(LOGMAXPKG), .REG_WORDS(16)) dut (
    .USB_IFCLK (clk),
    .RST_N     (rst_n),
    .USB_FLAGA (usb_flaga),
    .USB_FLAGB (1'b0),
    .USB_FLAGC (1'b0),
    .USB_FLAGD (usb_flagd),
    .USB_DATA  (usb_data),
    .USB_ADDR  (usb_addr),
    .USB_SLRD  (usb_slrd),
    .USB_SLWR  (usb_slwr),
    .USB_SLOE  (usb_sloe),
    .USB_PKEND (usb_pkend),
    .LED       (led),
    .COUNTER   (counter),
    .WB_RST    (wb_rst),
    .WB_STB    (wb_stb),
    .WB_WE     (wb_we),
    .WB_CYC    (wb_cyc),
    .WB_SEL    (wb_sel),
    .WB_ADDR   (wb_addr),
    .WB_DATA_I (wb_data_i),
    .WB_DATA_O (wb_data_o),
    .WB_STALL  (wb_stall),
    .WB_ACK    (wb_ack)
  );

  // Mid-cycle monitor: strobe legality, IN FIFO capture, PKEND and bus transfers.
  always @(negedge clk) begin
    ncyc++;
    rd_pend = !usb_slrd && usb_flaga;
    if (!usb_slrd && (!usb_flaga || usb_addr != 2'b00 || usb_sloe)) viol++;
    if (!usb_slwr) begin
      if (!usb_flagd || usb_addr != 2'b10) viol++;
      else begin
        in_mem[in_cnt[5:0]] = usb_data;
        in_cnt++;
      end
    end
    if (!usb_pkend) pk_cnt++;
    if (wb_cyc && wb_stb) begin
      txn_we      = wb_we;
      txn_sel     = wb_sel;
      txn_addr    = wb_addr;
      txn_dout    = wb_data_o;
      txn_counter = counter;
      stb_at      = ncyc;
    end
    if (wb_ack) begin
      txn_din = wb_data_i;
      ack_lat = ncyc - stb_at;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rd_pend) out_rd = out_rd + 6'd1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic startFrame(input logic [79:0] ws, input int n);
    tick();
    in0 = in_cnt;
    pk0 = pk_cnt;
    for (int i = 0; i < n; i++) begin
      out_mem[out_wr] = ws[79-16*i -: 16];
      out_wr = out_wr + 6'd1;
    end
  endtask

  task automatic waitFrame(input string tag);
    for (int i = 0; i < 300 && pk_cnt == pk0; i++) tick();
    tick();
    checkOutput({tag, "_pkend"}, pk_cnt - pk0, 1);
  endtask

  task automatic applyStimulus(input string tag, input logic [79:0] ws, input int n);
    startFrame(ws, n);
    waitFrame(tag);
  endtask

  task automatic checkResp(input string tag, input int n,
                           input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
    checkOutput({tag, "_nwords"}, in_cnt - in0, n);
    checkOutput({tag, "_w0"}, in_mem[in0[5:0]], e0);
    if (n > 1) begin
      checkOutput({tag, "_w1"}, in_mem[6'(in0 + 1)], e1);
      checkOutput({tag, "_w2"}, in_mem[6'(in0 + 2)], e2);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    flaga_en = 1'b0;
    flagd_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_slrd",  usb_slrd,  1);
    checkOutput("rst_slwr",  usb_slwr,  1);
    checkOutput("rst_sloe",  usb_sloe,  1);
    checkOutput("rst_pkend", usb_pkend, 1);
    checkOutput("rst_addr",  usb_addr,  0);
    checkOutput("rst_led",   led,       0);
    checkOutput("rst_cnt",   counter,   0);
    checkOutput("rst_wbrst", wb_rst,    1);
    checkOutput("rst_cyc",   {wb_cyc, wb_stb, wb_we, wb_ack, wb_stall}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("wbrst_rel", wb_rst, 0);
    flaga_en = 1'b1;
    flagd_en = 1'b1;

    $display("[TB] full-word write to reg0");
    applyStimulus("wr0", {16'h8F01, 16'h0000, 16'h0000, 16'h1234, 16'h5678}, 5);
    checkOutput("wr0_we",   txn_we,      1);
    checkOutput("wr0_sel",  txn_sel,     4'hF);
    checkOutput("wr0_addr", txn_addr,    32'h0);
    checkOutput("wr0_dout", txn_dout,    32'h12345678);
    checkOutput("wr0_cnt",  txn_counter, 5);
    checkOutput("wr0_lat",  ack_lat,     1);
    checkOutput("wr0_led",  led,         4'h8);
    checkResp("wr0", 1, 16'hA501, 16'h0, 16'h0);

    $display("[TB] read back reg0");
    applyStimulus("rd0", {16'h0F02, 16'h0000, 16'h0000, 32'h0}, 3);
    checkOutput("rd0_we",  txn_we,      0);
    checkOutput("rd0_din", txn_din,     32'h12345678);
    checkOutput("rd0_cnt", txn_counter, 3);
    checkResp("rd0", 3, 16'hA502, 16'h1234, 16'h5678);

    $display("[TB] flow control on both FIFOs");
    startFrame({16'h0F03, 16'h0000, 16'h0000, 32'h0}, 3);
    for (int i = 0; i < 50 && out_rd != 6'(out_wr - 6'd1); i++) tick();
    flaga_en = 1'b0;
    repeat (4) tick();
    flaga_en = 1'b1;
    for (int i = 0; i < 100 && in_cnt == in0; i++) tick();
    flagd_en = 1'b0;
    repeat (3) tick();
    flagd_en = 1'b1;
    waitFrame("flow");
    checkOutput("flow_outq", out_rd, out_wr);
    checkResp("flow", 3, 16'hA503, 16'h1234, 16'h5678);
    checkOutput("flow_viol", viol, 0);

    $display("[TB] byte-select write then read reg1");
    applyStimulus("bsw", {16'h8105, 16'h0000, 16'h0004, 16'hFFFF, 16'hFFAA}, 5);
    checkOutput("bsw_sel", txn_sel, 4'h1);
    checkOutput("bsw_led", led,     4'h8);
    checkResp("bsw", 1, 16'hA505, 16'h0, 16'h0);
    applyStimulus("bsr", {16'h0F06, 16'h0000, 16'h0004, 32'h0}, 3);
    checkOutput("bsr_din", txn_din, 32'h000000AA);
    checkResp("bsr", 3, 16'hA506, 16'h0000, 16'h00AA);

    $display("[TB] out-of-range read");
    applyStimulus("oor", {16'h0F07, 16'h0001, 16'h0000, 32'h0}, 3);
    checkOutput("oor_addr", txn_addr, 32'h00010000);
    checkOutput("oor_lat",  ack_lat,  1);
    checkResp("oor", 3, 16'hA507, 16'h0000, 16'h0000);

    $display("[TB] reset in the middle of a frame");
    startFrame({16'h8F08, 16'h0000, 48'h0}, 2);
    for (int i = 0; i < 50 && out_rd != out_wr; i++) tick();
    @(negedge clk);
    checkOutput("mid_cnt_pre", counter, 2);
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("mid_cnt",  counter,  0);
    checkOutput("mid_sloe", usb_sloe, 1);
    checkOutput("mid_slrd", usb_slrd, 1);
    checkOutput("mid_led",  led,      0);
    checkOutput("mid_cyc",  wb_cyc,   0);
    tick();
    rst_n = 1'b1;
    applyStimulus("post", {16'h0F09, 16'h0000, 16'h0000, 32'h0}, 3);
    checkResp("post", 3, 16'hA509, 16'h0000, 16'h0000);
    checkOutput("end_viol", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpga_usb_wb_bridge.md
Name: fpga_usb_wb_bridge

Overview:
Top-level FPGA block that bridges a Cypress FX2-style slave-FIFO USB interface to an internal 32-bit Wishbone bus. Command frames arrive from the host over the OUT endpoint FIFO. Each frame is executed as one Wishbone single transfer to an internal 16x32 register file. A response packet returns over the IN endpoint FIFO. Bus signals and a word counter are exported for debug; register 0 drives the LEDs.

Parameters:
LOGMAXPKG, 9, width of COUNTER (max words per frame = 2^LOGMAXPKG-1)
REG_WORDS, 16, number of 32-bit registers in the internal Wishbone slave

Ports:
USB_IFCLK  in  1  single system clock (FX2 interface clock), all logic on rising edge
RST_N  in  1  synchronous active-low reset
USB_FLAGA  in  1  OUT FIFO (EP2) not-empty, active high
USB_FLAGB  in  1  unused, ignored
USB_FLAGC  in  1  unused, ignored
USB_FLAGD  in  1  IN FIFO (EP6) not-full, active high
USB_DATA  inout  16  FIFO data bus
USB_ADDR  out  2  FIFO select: 2'b00 = EP2 OUT, 2'b10 = EP6 IN
USB_SLRD  out  1  read strobe, active low
USB_SLWR  out  1  write strobe, active low
USB_SLOE  out  1  FX2 output enable, active low
USB_PKEND  out  1  packet commit, active-low one-cycle pulse
LED  out  4  reg0[3:0]
COUNTER  out  LOGMAXPKG  OUT words consumed in current frame
WB_RST, WB_STB, WB_WE, WB_CYC  out  1 each  Wishbone master controls (debug export)
WB_SEL  out  4  byte selects
WB_ADDR  out  32  byte address
WB_DATA_I  out  32  slave-to-master read data
WB_DATA_O  out  32  master-to-slave write data
WB_STALL, WB_ACK  out  1 each  slave responses

Behaviour:
- Reset, sampled on USB_IFCLK: SLRD=SLWR=SLOE=PKEND=1, USB_ADDR=00, USB_DATA=Z, all WB_* outputs=0 except WB_RST, LED=0, COUNTER=0, register file cleared, FSM=IDLE. WB_RST = registered ~RST_N.
- Frame format (OUT), word 0 = header: [15]=WE, [11:8]=SEL, [7:0]=TAG.
  - W1=ADDR[31:16], W2=ADDR[15:0].
  - Writes only: W3=DATA[31:16], W4=DATA[15:0].
  - Read frame = 3 words; write frame = 5 words.
- OUT read handshake:
  - USB_ADDR=00, SLOE=0 throughout read states.
  - SLRD=0 only in cycles where FLAGA=1.
  - The word is captured on the same rising edge where SLRD=0 and FLAGA=1; COUNTER increments on that edge.
  - FLAGA=0 stalls (SLRD=1) with no timeout.
- FSM states:
  - IDLE: COUNTER<=0; go to RD when FLAGA=1.
  - RD: collect frame words; when the last word is captured, SLOE<=1 and go to WB.
  - WB: CYC=STB=1, WE/SEL/ADDR/DATA_O from frame; STB deasserts on the cycle after acceptance (STALL=0); wait for ACK.
  - TURN: one idle cycle with bus undriven.
  - WR: USB_ADDR=10; FPGA drives USB_DATA; SLWR=0 one cycle per word, only when FLAGD=1. FLAGD=0 holds the current word and SLWR=1.
  - PKEND: PKEND=0 for one cycle, then IDLE.
- Response (IN):
  - Word 0 = {8'hA5, TAG}, always sent.
  - Read frames add DATA[31:16], DATA[15:0].
  - Write response = 1 word, read response = 3 words.
- Internal slave:
  - STALL constant 0; ACK one cycle after STB&CYC, for one cycle.
  - Index = ADDR[5:2]; ADDR[31:6]≠0 is out of range: ack, read 0, write ignored.
  - Writes honour SEL per byte.
  - DATA_I is valid with ACK and 0 otherwise.
- USB_DATA is driven only in WR state with SLOE=1; Z in every other state.
- COUNTER saturates at 2^LOGMAXPKG-1.
- Reset asserted mid-frame aborts immediately to the reset state; partial frame discarded.

Test Plan:
- Reset: hold RST_N=0 for 3 cycles -> SLRD/SLWR/SLOE/PKEND=1, LED=0, COUNTER=0, USB_DATA=Z, WB_RST=1 then 0.
- Write frame 8F01,0000,0000,1234,5678 with FLAGA=1, FLAGD=1 -> WB write ADDR=0, SEL=F, DATA_O=12345678, LED=8; IN receives A501; one PKEND pulse; COUNTER=5.
- Read frame 0F02,0000,0000 after the write -> WB_DATA_I=12345678 with ACK; IN receives A502,1234,5678, then PKEND.
- Byte-select write 8105,0000,0004,FFFF,FFAA then read 0F06,0000,0004 -> response A506,0000,00AA.
- Flow control: drop FLAGA for 4 cycles mid-frame and FLAGD for 3 cycles mid-response -> no SLRD/SLWR while flag low, no lost or duplicated words.
- Out-of-range read 0F07,0001,0000 -> ACK in 1 cycle, response A507,0000,0000; RST_N=0 mid-frame -> immediate return to reset state.
